// File: rtl/ram_arbiter.sv
// Two-master access controller for the 256x8 CDEC program/data RAM.
// Arbitrates the CPU and the loader round-robin. Each access runs IDLE -> ACCESS -> DONE.
module ram_arbiter #(
  parameter int ADRS_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADRS_W-1:0] cpu_adrs,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADRS_W-1:0] ldr_adrs,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  input  logic              ldr_lock,
  output logic [DATA_W-1:0] rdata,
  output logic [ADRS_W-1:0] ram_adrs,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic OWNER_LDR = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [ADRS_W-1:0] ram_adrs_q,  ram_adrs_d;
  logic [DATA_W-1:0] ram_data_q,  ram_data_d;
  logic              ram_wr_en_q, ram_wr_en_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              cpu_ack_q,   cpu_ack_d;
  logic              ldr_ack_q,   ldr_ack_d;

  logic cpu_elig;
  logic ldr_elig;
  logic grant_cpu;

  assign cpu_elig = cpu_req & ~ldr_lock;
  assign ldr_elig = ldr_req;
  // On a tie the master that was not served last wins. owner_q doubles as the last-owner flag.
  assign grant_cpu = cpu_elig & (~ldr_elig | (owner_q == OWNER_LDR));

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    ram_adrs_d  = ram_adrs_q;
    ram_data_d  = ram_data_q;
    ram_wr_en_d = ram_wr_en_q;
    rdata_d     = rdata_q;
    cpu_ack_d   = cpu_ack_q;
    ldr_ack_d   = ldr_ack_q;

    case (state_q)
      IDLE: begin
        if (cpu_elig || ldr_elig) begin
          owner_d     = grant_cpu ? OWNER_CPU : OWNER_LDR;
          ram_adrs_d  = grant_cpu ? cpu_adrs  : ldr_adrs;
          ram_data_d  = grant_cpu ? cpu_wdata : ldr_wdata;
          ram_wr_en_d = grant_cpu ? cpu_we    : ldr_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM latched the address on the negedge inside this cycle, so ram_q already reflects this access.
        rdata_d     = ram_q;
        cpu_ack_d   = (owner_q == OWNER_CPU);
        ldr_ack_d   = (owner_q == OWNER_LDR);
        ram_wr_en_d = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        cpu_ack_d = 1'b0;
        ldr_ack_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        ram_wr_en_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_LDR;
      ram_adrs_q  <= '0;
      ram_data_q  <= '0;
      ram_wr_en_q <= 1'b0;
      rdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_adrs_q  <= ram_adrs_d;
      ram_data_q  <= ram_data_d;
      ram_wr_en_q <= ram_wr_en_d;
      rdata_q     <= rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign rdata     = rdata_q;
  assign ram_adrs  = ram_adrs_q;
  assign ram_data  = ram_data_q;
  assign ram_wr_en = ram_wr_en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 256x8 RAM (negedge write, registered address).
// It runs directed arbitration, lock and reset scenarios, then a randomized two-master phase.
module tb_ram_arbiter;
  localparam int ADRS_W = 8;
  localparam int DATA_W = 8;
  localparam int BUDGET = 400;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [ADRS_W-1:0] cpu_adrs, ldr_adrs;
  logic [DATA_W-1:0] cpu_wdata, ldr_wdata;
  logic              cpu_ack, ldr_ack, ram_wr_en;
  logic [DATA_W-1:0] rdata, ram_data, ram_q;
  logic [ADRS_W-1:0] ram_adrs;

  ram_arbiter #(.ADRS_W(ADRS_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adrs(ldr_adrs), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .ldr_lock(ldr_lock), .rdata(rdata),
    .ram_adrs(ram_adrs), .ram_data(ram_data), .ram_wr_en(ram_wr_en), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input int i);
    int v;
    v = (i * 37 + 11) & 255;
    return (i == 8) ? 8'h03 : 8'(v);
  endfunction

  // Behavioural RAM: writes and latches the address on negedge, so read-after-write returns new data.
  logic [7:0] mem [256];
  logic [7:0] adrs_lat = 8'h00;
  bit         mem_init_done = 1'b0;
  always @(negedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      mem_init_done = 1'b1;
    end
    if (ram_wr_en) mem[ram_adrs] = ram_data;
    adrs_lat = ram_adrs;
  end
  assign ram_q = mem[adrs_lat];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { bit is_cpu; int cyc; } ack_t;

  logic [7:0] ref_mem [256];
  logic [7:0] exp_cpu_q [$];
  logic [7:0] exp_ldr_q [$];
  ack_t       ack_log [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_wr_exp = 0;
  int wr_cnt  = 0;
  bit cpu_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Caller is positioned 1 time unit after a posedge; the task returns in the same position.
  task automatic cpu_do(input logic we, input logic [7:0] a, input logic [7:0] d, output int lat);
    int  c0;
    bit  got;
    if (we) begin ref_mem[a] = d; n_wr_exp++; exp_cpu_q.push_back(d); end
    else exp_cpu_q.push_back(ref_mem[a]);
    cpu_we = we; cpu_adrs = a; cpu_wdata = d; cpu_req = 1'b1;
    c0 = cyc; got = 1'b0; lat = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clock);
      if (cpu_ack) begin got = 1'b1; lat = cyc - c0; break; end
    end
    if (!got) begin
      fail_event("cpu_ack_timeout", "no cpu_ack within budget");
      void'(exp_cpu_q.pop_back());
    end
    @(posedge clock); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ldr_do(input logic we, input logic [7:0] a, input logic [7:0] d, output int lat);
    int  c0;
    bit  got;
    if (we) begin ref_mem[a] = d; n_wr_exp++; exp_ldr_q.push_back(d); end
    else exp_ldr_q.push_back(ref_mem[a]);
    ldr_we = we; ldr_adrs = a; ldr_wdata = d; ldr_req = 1'b1;
    c0 = cyc; got = 1'b0; lat = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clock);
      if (ldr_ack) begin got = 1'b1; lat = cyc - c0; break; end
    end
    if (!got) begin
      fail_event("ldr_ack_timeout", "no ldr_ack within budget");
      void'(exp_ldr_q.pop_back());
    end
    @(posedge clock); #1;
    ldr_req = 1'b0;
  endtask

  task automatic wait_acks(input int n, input string name);
    int k;
    k = 0;
    while (ack_log.size() < n && k < BUDGET) begin
      @(negedge clock); #1;
      k++;
    end
    if (ack_log.size() < n) fail_event(name, "expected ack count not reached within budget");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, base, lat2;
    bit  prev_cpu_ack, prev_ldr_ack, prev_wr;

    reset_n = 1'b0; ldr_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adrs = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_adrs = '0; ldr_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    prev_cpu_ack = 1'b0; prev_ldr_ack = 1'b0; prev_wr = 1'b0;

    // Monitor: pops the scoreboard on every ack and checks the pulse-level invariants.
    fork
      forever begin
        @(negedge clock);
        if (cpu_ack || ldr_ack) check("ack_exclusive", 32'(cpu_ack & ldr_ack), 0);
        if (cpu_ack) begin
          if (prev_cpu_ack) fail_event("cpu_ack_width", "cpu_ack high for more than one cycle");
          if (exp_cpu_q.size() == 0) fail_event("cpu_unexpected_ack", "cpu_ack with nothing outstanding");
          else check("cpu_rdata", rdata, exp_cpu_q.pop_front());
          ack_log.push_back('{1'b1, cyc});
        end
        if (ldr_ack) begin
          if (prev_ldr_ack) fail_event("ldr_ack_width", "ldr_ack high for more than one cycle");
          if (exp_ldr_q.size() == 0) fail_event("ldr_unexpected_ack", "ldr_ack with nothing outstanding");
          else check("ldr_rdata", rdata, exp_ldr_q.pop_front());
          ack_log.push_back('{1'b0, cyc});
        end
        if (ram_wr_en) begin
          if (prev_wr) fail_event("wr_en_width", "ram_wr_en high across two negedges");
          wr_cnt++;
        end
        prev_cpu_ack = cpu_ack; prev_ldr_ack = ldr_ack; prev_wr = ram_wr_en;
      end
    join_none

    #12;
    check("reset_cpu_ack", cpu_ack, 0);
    check("reset_ldr_ack", ldr_ack, 0);
    check("reset_rdata", rdata, 0);
    check("reset_ram_adrs", ram_adrs, 0);
    check("reset_ram_data", ram_data, 0);
    check("reset_ram_wr_en", ram_wr_en, 0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // Contention straight after reset: CPU, loader, CPU, loader, 3 cycles apart.
    base = ack_log.size();
    repeat (2) begin exp_cpu_q.push_back(ref_mem[8'h08]); exp_ldr_q.push_back(ref_mem[8'h88]); end
    cpu_we = 1'b0; cpu_adrs = 8'h08; ldr_we = 1'b0; ldr_adrs = 8'h88;
    cpu_req = 1'b1; ldr_req = 1'b1;
    wait_acks(base + 4, "contention_acks");
    cpu_req = 1'b0; ldr_req = 1'b0;
    if (ack_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("contention_order", 32'(ack_log[base+i].is_cpu), 32'((i % 2) == 0));
        if (i > 0) check("contention_spacing", ack_log[base+i].cyc - ack_log[base+i-1].cyc, 3);
      end
    end
    @(posedge clock); #1;
    @(posedge clock); #1;

    // Single CPU read of the preloaded word: ack two edges after the req edge.
    cpu_do(1'b0, 8'h08, 8'h00, lat);
    check("cpu_read_latency", lat, 2);

    // Loader write then CPU read of the same word; exactly one write cycle.
    base = wr_cnt;
    ldr_do(1'b1, 8'h09, 8'h5A, lat);
    check("ldr_write_latency", lat, 2);
    cpu_do(1'b0, 8'h09, 8'h00, lat);
    check("wr_en_one_cycle", wr_cnt - base, 1);

    // Back-to-back CPU accesses: new fields at the ack edge, 3-cycle ack interval.
    base = ack_log.size();
    cpu_do(1'b0, 8'h20, 8'h00, lat);
    cpu_do(1'b0, 8'h21, 8'h00, lat2);
    check("b2b_latency", lat2, 2);
    if (ack_log.size() >= base + 2) check("b2b_interval", ack_log[base+1].cyc - ack_log[base].cyc, 3);

    // Lock: only the loader is served; releasing it hands the tie to the CPU.
    base = ack_log.size();
    repeat (4) exp_ldr_q.push_back(ref_mem[8'hA0]);
    exp_cpu_q.push_back(ref_mem[8'h10]);
    cpu_we = 1'b0; cpu_adrs = 8'h10; ldr_we = 1'b0; ldr_adrs = 8'hA0;
    ldr_lock = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
    wait_acks(base + 3, "lock_acks");
    ldr_lock = 1'b0;
    wait_acks(base + 5, "unlock_acks");
    cpu_req = 1'b0; ldr_req = 1'b0;
    if (ack_log.size() >= base + 5) begin
      for (int i = 0; i < 3; i++) check("lock_owner", 32'(ack_log[base+i].is_cpu), 0);
      check("unlock_first_cpu", 32'(ack_log[base+3].is_cpu), 1);
      check("unlock_then_ldr", 32'(ack_log[base+4].is_cpu), 0);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;

    // Reset in the middle of a CPU write: write enable and acks drop at once.
    cpu_we = 1'b1; cpu_adrs = 8'h50; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    @(posedge clock); #2;
    check("wr_en_in_access", ram_wr_en, 1);
    reset_n = 1'b0;
    #1;
    check("abort_wr_en", ram_wr_en, 0);
    check("abort_cpu_ack", cpu_ack, 0);
    check("abort_ldr_ack", ldr_ack, 0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("rerst_ram_adrs", ram_adrs, 0);
    check("rerst_ram_data", ram_data, 0);
    check("rerst_rdata", rdata, 0);

    // First tie after reset goes to the CPU; the aborted word is rewritten here.
    base = ack_log.size();
    ref_mem[8'h50] = 8'h77; n_wr_exp++;
    exp_cpu_q.push_back(8'h77);
    exp_ldr_q.push_back(ref_mem[8'h90]);
    cpu_we = 1'b1; cpu_adrs = 8'h50; cpu_wdata = 8'h77; ldr_we = 1'b0; ldr_adrs = 8'h90;
    cpu_req = 1'b1; ldr_req = 1'b1;
    wait_acks(base + 1, "tie_first_ack");
    cpu_req = 1'b0;
    wait_acks(base + 2, "tie_second_ack");
    ldr_req = 1'b0;
    if (ack_log.size() >= base + 2) begin
      check("tie_cpu_first", 32'(ack_log[base].is_cpu), 1);
      check("tie_ldr_second", 32'(ack_log[base+1].is_cpu), 0);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;

    // Randomized phase: disjoint address halves per master, lock toggling in the background.
    fork
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          cpu_do(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom), l);
        end
        cpu_done = 1'b1;
      end
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          ldr_do(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 8'($urandom), l);
        end
      end
      begin
        while (!cpu_done) begin
          repeat ($urandom_range(2, 15)) @(posedge clock);
          #1;
          ldr_lock = cpu_done ? 1'b0 : ~ldr_lock;
        end
        ldr_lock = 1'b0;
      end
    join

    repeat (4) @(posedge clock);
    #1;
    check("wr_en_total", wr_cnt, n_wr_exp);
    check("cpu_queue_drained", exp_cpu_q.size(), 0);
    check("ldr_queue_drained", exp_ldr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port access controller for the 256x8 program/data RAM in the CDEC design. Shares the RAM's single address/data/write port between the CPU memory interface and the loader/monitor interface, which writes program images and reads back results. Sequences each access over the RAM's negedge-write, registered-address timing, and returns read data with a one-cycle acknowledge. Sits between the CPU core, the loader, and the RAM instance.

## Interface
- ADRS_W, 8, address width; must match RAM depth (256 words).
- DATA_W, 8, data width.

- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held until ack sampled.
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
- cpu_adrs  input  ADRS_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse for CPU.
- ldr_req  input  1  loader access request.
- ldr_we  input  1  loader write enable.
- ldr_adrs  input  ADRS_W  loader address.
- ldr_wdata  input  DATA_W  loader write data.
- ldr_ack  output  1  one-cycle completion pulse for loader.
- ldr_lock  input  1  loader owns RAM exclusively while high.
- rdata  output  DATA_W  read data; valid while cpu_ack or ldr_ack is high.
- ram_adrs  output  ADRS_W  to RAM adrs.
- ram_data  output  DATA_W  to RAM data.
- ram_wr_en  output  1  to RAM wr_en.
- ram_q  input  DATA_W  from RAM q.

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if any eligible req is high, choose the winner, register ram_adrs/ram_data/ram_wr_en from its fields, record the owner, then go to ACCESS. If no eligible req is high, stay in IDLE.
- Eligibility: ldr_req is always eligible. cpu_req is eligible only when ldr_lock = 0.
- Arbitration: round-robin via a last_owner flag (reset = loader, so the CPU wins the first tie). When both are eligible, grant the non-last owner. A lone requester is always granted.
- ACCESS (exactly 1 cycle): ram_wr_en is high only here if we = 1. The RAM writes and latches the address on the negedge inside this cycle. At the closing posedge, capture ram_q into rdata, set the owner's ack to 1, clear ram_wr_en, and go to DONE.
- DONE (exactly 1 cycle): the ack is high. At the closing posedge, clear the ack and go to IDLE. No arbitration happens in DONE.
- Write ack: rdata carries the newly written value, because the RAM's read-after-write at the same address returns new data.
- ram_adrs/ram_data hold their last values outside ACCESS. Only ram_wr_en is forced to 0.
- ldr_lock changing mid-access does not abort the access. It affects only the next IDLE decision.
- Requester rule: deassert req, or present new fields for the next access, at the edge where ack is sampled high. IDLE re-samples req one edge later.

## Timing
- Reset values: cpu_ack=0, ldr_ack=0, rdata=0, ram_adrs=0, ram_data=0, ram_wr_en=0, state IDLE, last_owner=loader.
- Reset is asynchronous. Asserting reset_n low mid-ACCESS drops ram_wr_en immediately, and no ack is issued. Whether the RAM completes the in-flight write depends on negedge timing; the bench must not rely on it either way.
- Latency: req is sampled at posedge N, the ack is high between posedges N+1 and N+2, and rdata is valid during that window.
- Throughput: one access per 3 cycles. With both masters continuously requesting, grants alternate CPU, loader, CPU, and so on.
- ram_wr_en is high for exactly one clock period per write, which covers exactly one negedge.
- cpu_ack and ldr_ack are never high together.

## Test plan
- Single CPU read: RAM preloaded with ram[0x08]=0x03. Hold cpu_req=1, cpu_we=0, cpu_adrs=0x08 -> cpu_ack high 1 cycle, 2 edges after the req edge, with rdata=0x03. ldr_ack stays 0.
- Loader write then CPU read: loader writes 0x5A to 0x09 -> ldr_ack with rdata=0x5A. Then a CPU read of 0x09 -> rdata=0x5A. ram_wr_en is high for exactly one cycle in total.
- Contention: both requesters held high continuously after reset -> acks in order CPU, loader, CPU, loader. Each ack is separated by 3 cycles and there are no double acks.
- Lock: ldr_lock=1 with both requesting -> only ldr_ack pulses, and cpu_req starves. Dropping ldr_lock -> the next grant goes to the CPU when the loader was the last owner.
- Reset mid-access: pull reset_n low during ACCESS of a CPU write -> ram_wr_en=0 and all acks=0 immediately. After release, the state is IDLE and the CPU wins the first tie.
- Back-to-back: CPU presents a new address at its ack edge -> second access is granted at the following IDLE edge, and the ack interval is 3 cycles.
